shiftreg_capture: RTL and testbench

// Serial-to-parallel capture register: receiving end of the LSB-first, one-bit-per-enabled-cycle

---
 rtl/shiftreg_capture.sv | 113 +++++++++++
 tb/tb_shiftreg_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_capture.sv
// -----------------------------------------------------------------------------
// shiftreg_capture
//
// Serial-to-parallel capture register on the MMM result/operand return path.
// Collects WIDTH bits from an LSB-first serial stream (one bit per enabled
// cycle) into a word and presents the completed word with a done flag.
//
// Ports
//   clk        in   1      rising-edge clock
//   rstb       in   1      synchronous active-low reset
//   en         in   1      clock enable; shifting/counting only when 1
//   rst_mmm_i  in   1      synchronous active-low clear of capture state
//   start      in   1      single-cycle pulse: begin (or restart) a capture
//   bit_in     in   1      serial data, LSB first, sampled when en=1 in SHIFT
//   data_o     out  WIDTH  last completed word; stable between completions
//   busy_o     out  1      1 while capturing (SHIFT)
//   done_o     out  1      1 while the word in data_o is fresh (DONE)
//   state_o    out  2      FSM state for observation (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: start is a one-cycle request with no ready; it is accepted on
// every edge unless a reset is active and always wins over shifting. done_o
// acts as a level valid for data_o: it rises on the edge that stores the
// final bit and stays high until the next start or reset. busy_o and done_o
// are decodes of the state register only, so neither has a combinational path
// from any input.
// -----------------------------------------------------------------------------
module shiftreg_capture #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             rst_mmm_i,
  input  logic             start,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] shifted;

  // New bits enter at the top and walk down, so the first bit received
  // ends up in bit 0 once WIDTH bits have been taken.
  assign shifted = {bit_in, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    if (start) begin
      // Start (or abort-and-restart) clears the partial word but leaves
      // data_o alone; bit_in is not sampled on this cycle.
      state_d = SHIFT;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (en) begin
            shreg_d = shifted;
            if (cnt_q == LAST) begin
              data_d  = shifted;
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb || !rst_mmm_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign busy_o  = (state_q == SHIFT);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_shiftreg_capture.sv
// -----------------------------------------------------------------------------
// tb_shiftreg_capture
//
// Two instances share the stimulus: dut4 (WIDTH=4) runs the directed vector
// table, dut8 (WIDTH=8) runs the random LSB-first loopback against a
// bit-queue model of the capture behaviour.
// -----------------------------------------------------------------------------
module tb_shiftreg_capture;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb, en, rst_mmm, start, bit_in;

  logic [3:0] data4;
  logic       busy4, done4;
  logic [1:0] st4;
  logic [7:0] data8;
  logic       busy8, done8;
  logic [1:0] st8;

  shiftreg_capture #(.WIDTH(4)) dut4 (
    .clk(clk), .rstb(rstb), .en(en), .rst_mmm_i(rst_mmm), .start(start),
    .bit_in(bit_in), .data_o(data4), .busy_o(busy4), .done_o(done4),
    .state_o(st4)
  );

  shiftreg_capture #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .en(en), .rst_mmm_i(rst_mmm), .start(start),
    .bit_in(bit_in), .data_o(data8), .busy_o(busy8), .done_o(done8),
    .state_o(st8)
  );

  // ---------------- counters ----------------
  int vectors     = 0;
  int miscompares = 0;

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       rb, rm, st, e, b;
    logic       exp_busy, exp_done;
    logic [3:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string n, logic rb, logic rm, logic st, logic e,
                              logic b, logic eb, logic ed, logic [3:0] d);
    vec_t v;
    v.name = n; v.rb = rb; v.rm = rm; v.st = st; v.e = e; v.b = b;
    v.exp_busy = eb; v.exp_done = ed; v.exp_data = d;
    tbl.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(logic rb, logic rm, logic st, logic e, logic b);
    @(negedge clk);
    rstb = rb; rst_mmm = rm; start = st; en = e; bit_in = b;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(string n, logic eb, logic ed, logic [3:0] d);
    vectors++;
    if (busy4 !== eb || done4 !== ed || data4 !== d) begin
      miscompares++;
      $display("FAIL %s: got busy=%0b done=%0b data=%h, want busy=%0b done=%0b data=%h",
               n, busy4, done4, data4, eb, ed, d);
    end
  endtask

  // ---------------- scoreboard / reference model (WIDTH=8) ----------------
  logic [7:0] exp_q[$];   // words sent, in order
  logic       bits_q[$];  // bits the model has accepted into the current word
  logic       m_busy, m_done;
  logic [7:0] m_data;

  // Apply the capture rules to the model for the edge that just happened.
  function automatic void model_edge(logic rb, logic rm, logic st, logic e, logic b);
    if (!rb || !rm) begin
      bits_q.delete(); m_busy = 0; m_done = 0; m_data = '0;
    end else if (st) begin
      bits_q.delete(); m_busy = 1; m_done = 0;
    end else if (m_busy && e) begin
      bits_q.push_back(b);
      if (bits_q.size() == 8) begin
        m_data = '0;
        for (int i = 0; i < 8; i++) m_data[i] = bits_q[i];
        bits_q.delete();
        m_busy = 0; m_done = 1;
      end
    end
  endfunction

  task automatic step8(string n, logic rb, logic rm, logic st, logic e, logic b);
    drive(rb, rm, st, e, b);
    settle();
    model_edge(rb, rm, st, e, b);
    vectors++;
    if (busy8 !== m_busy || done8 !== m_done || data8 !== m_data) begin
      miscompares++;
      $display("FAIL %s: got busy=%0b done=%0b data=%h, want busy=%0b done=%0b data=%h",
               n, busy8, done8, data8, m_busy, m_done, m_data);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] w;
    int         idx, k;
    logic       e, b;

    rstb = 0; rst_mmm = 1; start = 0; en = 0; bit_in = 0;

    //   name              rb rm st e  b   busy done data
    add("rst",              0, 1, 0, 0, 0,  0, 0, 4'h0);
    add("idle_en",          1, 1, 0, 1, 1,  0, 0, 4'h0);
    // T1: 1,0,1,1 with en held; bit on start cycle is ignored
    add("t1_start",         1, 1, 1, 1, 1,  1, 0, 4'h0);
    add("t1_b0",            1, 1, 0, 1, 1,  1, 0, 4'h0);
    add("t1_b1",            1, 1, 0, 1, 0,  1, 0, 4'h0);
    add("t1_b2",            1, 1, 0, 1, 1,  1, 0, 4'h0);
    add("t1_b3",            1, 1, 0, 1, 1,  0, 1, 4'hD);
    add("t1_hold",          1, 1, 0, 1, 0,  0, 1, 4'hD);
    // T2: same stream, en toggling; junk bit on each en=0 cycle
    add("t2_start",         1, 1, 1, 0, 0,  1, 0, 4'hD);
    add("t2_b0",            1, 1, 0, 1, 1,  1, 0, 4'hD);
    add("t2_gap0",          1, 1, 0, 0, 1,  1, 0, 4'hD);
    add("t2_b1",            1, 1, 0, 1, 0,  1, 0, 4'hD);
    add("t2_gap1",          1, 1, 0, 0, 0,  1, 0, 4'hD);
    add("t2_b2",            1, 1, 0, 1, 1,  1, 0, 4'hD);
    add("t2_gap2",          1, 1, 0, 0, 0,  1, 0, 4'hD);
    add("t2_b3",            1, 1, 0, 1, 1,  0, 1, 4'hD);
    // T3: two bits, abort, then 0,0,0,1
    add("t3_start",         1, 1, 1, 1, 1,  1, 0, 4'hD);
    add("t3_b0",            1, 1, 0, 1, 1,  1, 0, 4'hD);
    add("t3_b1",            1, 1, 0, 1, 1,  1, 0, 4'hD);
    add("t3_restart",       1, 1, 1, 1, 1,  1, 0, 4'hD);
    add("t3_c0",            1, 1, 0, 1, 0,  1, 0, 4'hD);
    add("t3_c1",            1, 1, 0, 1, 0,  1, 0, 4'hD);
    add("t3_c2",            1, 1, 0, 1, 0,  1, 0, 4'hD);
    add("t3_c3",            1, 1, 0, 1, 1,  0, 1, 4'h8);
    // T4: capture A, then MMM clear in DONE; clear beats start
    add("t4_start",         1, 1, 1, 1, 0,  1, 0, 4'h8);
    add("t4_b0",            1, 1, 0, 1, 0,  1, 0, 4'h8);
    add("t4_b1",            1, 1, 0, 1, 1,  1, 0, 4'h8);
    add("t4_b2",            1, 1, 0, 1, 0,  1, 0, 4'h8);
    add("t4_b3",            1, 1, 0, 1, 1,  0, 1, 4'hA);
    add("t4_clr",           1, 0, 0, 1, 1,  0, 0, 4'h0);
    add("t4_idle",          1, 1, 0, 1, 1,  0, 0, 4'h0);
    add("t4_clr_vs_start",  1, 0, 1, 1, 1,  0, 0, 4'h0);
    // T5: rstb mid-SHIFT, rstb beats start, then capture 5
    add("t5_start",         1, 1, 1, 1, 0,  1, 0, 4'h0);
    add("t5_a0",            1, 1, 0, 1, 1,  1, 0, 4'h0);
    add("t5_a1",            1, 1, 0, 1, 1,  1, 0, 4'h0);
    add("t5_rstb",          0, 1, 0, 1, 1,  0, 0, 4'h0);
    add("t5_rstb_vs_start", 0, 1, 1, 1, 1,  0, 0, 4'h0);
    add("t5_start2",        1, 1, 1, 1, 0,  1, 0, 4'h0);
    add("t5_b0",            1, 1, 0, 1, 1,  1, 0, 4'h0);
    add("t5_b1",            1, 1, 0, 1, 0,  1, 0, 4'h0);
    add("t5_b2",            1, 1, 0, 1, 1,  1, 0, 4'h0);
    add("t5_b3",            1, 1, 0, 1, 0,  0, 1, 4'h5);
    // Restart from DONE: done drops, data held
    add("done_restart",     1, 1, 1, 1, 1,  1, 0, 4'h5);

    foreach (tbl[i]) begin
      drive(tbl[i].rb, tbl[i].rm, tbl[i].st, tbl[i].e, tbl[i].b);
      settle();
      check4(tbl[i].name, tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_data);
    end

    // T6: random LSB-first loopback on the 8-bit instance
    step8("t6_reset", 0, 1, 0, 0, 0);
    for (int word = 0; word < 100; word++) begin
      w = 8'($urandom_range(0, 255));
      step8("t6_start", 1, 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        // partial junk word, then abort
        k = $urandom_range(1, 6);
        for (int j = 0; j < k; j++)
          step8("t6_junk", 1, 1, 0, 1, 1'($urandom_range(0, 1)));
        step8("t6_abort", 1, 1, 1, 1, 1'($urandom_range(0, 1)));
      end
      exp_q.push_back(w);
      idx = 0;
      while (idx < 8) begin
        e = ($urandom_range(0, 2) != 0);
        b = e ? w[idx] : 1'($urandom_range(0, 1));
        step8("t6_bit", 1, 1, 0, e, b);
        if (e) idx++;
      end
      vectors++;
      if (done8 !== 1'b1 || data8 !== exp_q[0]) begin
        miscompares++;
        $display("FAIL t6_word%0d: got done=%0b data=%h, want done=1 data=%h",
                 word, done8, data8, exp_q[0]);
      end
      void'(exp_q.pop_front());
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++)
        step8("t6_idle", 1, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
